// File: rtl/eth_rx_mac_filter.sv
// ---------------------------------------------------------------------------
// eth_rx_mac_filter
//
// Destination-MAC filter on the 8-bit AXI-Stream receive path. The first six
// bytes of every frame (the destination MAC) are held in a header buffer.
// The frame is then either replayed and forwarded unchanged, or silently
// consumed. Frames that end inside their first six bytes (runts) are always
// consumed.
//
// Acceptance is decided on the 6th header beat. A frame is accepted if any of
// these hold:
//   - promiscuous mode is on;
//   - the header equals the station address;
//   - the header is broadcast (all 0xFF);
//   - multicast is enabled and bit 0 of byte 0 is set.
//
// Parameters:
//   UserWidth     - tuser width, forwarded unchanged on every beat
//   CntWidth      - width of the saturating statistics counters
//
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   mac_addr_i    - station MAC; byte k of the frame compares to [8k+7:8k]
//   promisc_i     - accept every frame of 6 bytes or more
//   mcast_en_i    - accept frames whose byte 0 has bit 0 set
//   s_axis_*      - input stream from the framing core
//   m_axis_*      - output stream to the upsizer
//   pass_cnt_o    - saturating count of accepted frames
//   drop_cnt_o    - saturating count of rejected frames, runts included
//   runt_o        - one-cycle pulse after a frame ends within 6 bytes
//
// Build option:
//   ETH_RX_MAC_FILTER_STATS_EN - when defined, the counters and runt_o are
//   implemented. When undefined, they are tied to zero and no counter flops
//   exist.
// ---------------------------------------------------------------------------
module eth_rx_mac_filter #(
    parameter int UserWidth = 1,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [47:0]          mac_addr_i,
    input  logic                 promisc_i,
    input  logic                 mcast_en_i,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic [UserWidth-1:0] s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [UserWidth-1:0] m_axis_tuser,
    output logic [CntWidth-1:0]  pass_cnt_o,
    output logic [CntWidth-1:0]  drop_cnt_o,
    output logic                 runt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FLUSH = 3'd2,
        S_PASS  = 3'd3,
        S_DROP  = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic [2:0] idx_q, idx_d;

    // Header buffer: one entry per destination-MAC byte.
    logic [7:0]           hdr_data_q [6];
    logic                 hdr_last_q [6];
    logic [UserWidth-1:0] hdr_user_q [6];

    logic        hdr_phase;
    logic        hdr_fire;
    logic        last_hdr_beat;
    logic [47:0] hdr_word;
    logic        addr_match;
    logic        bcast;
    logic        accept;
    logic        flush_done;

    assign hdr_phase     = (state_q == S_IDLE) || (state_q == S_HDR);
    assign hdr_fire      = hdr_phase && s_axis_tvalid && s_axis_tready;
    assign last_hdr_beat = (idx_q == 3'd5);

    // The 6th byte is still on the input bus when the decision is made, so it
    // is taken straight from s_axis_tdata rather than from the buffer.
    assign hdr_word   = {s_axis_tdata, hdr_data_q[4], hdr_data_q[3],
                         hdr_data_q[2], hdr_data_q[1], hdr_data_q[0]};
    assign addr_match = (hdr_word == mac_addr_i);
    assign bcast      = &hdr_word;
    assign accept     = promisc_i || addr_match || bcast ||
                        (mcast_en_i && hdr_data_q[0][0]);

    assign flush_done = (state_q == S_FLUSH) && m_axis_tready && last_hdr_beat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The buffer contents are only ever read after being written in the
    // current frame, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (hdr_fire) begin
            hdr_data_q[idx_q] <= s_axis_tdata;
            hdr_last_q[idx_q] <= s_axis_tlast;
            hdr_user_q[idx_q] <= s_axis_tuser;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'd0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;

        case (state_q)
            S_IDLE, S_HDR: begin
                // Held low while in reset so no beat is taken during reset.
                s_axis_tready = !rst_i;
                if (hdr_fire) begin
                    if (last_hdr_beat) begin
                        idx_d = 3'd0;
                        if (accept) begin
                            state_d = S_FLUSH;
                        end else if (s_axis_tlast) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else if (s_axis_tlast) begin
                        // Runt: the frame ended inside the header.
                        idx_d   = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_HDR;
                    end
                end
            end

            S_FLUSH: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_data_q[idx_q];
                m_axis_tlast  = hdr_last_q[idx_q];
                m_axis_tuser  = hdr_user_q[idx_q];
                if (flush_done) begin
                    idx_d   = 3'd0;
                    state_d = hdr_last_q[5] ? S_IDLE : S_PASS;
                end else if (m_axis_tready) begin
                    idx_d = idx_q + 3'd1;
                end
            end

            S_PASS: begin
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_d = S_IDLE;
                end
            end

            S_DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

`ifdef ETH_RX_MAC_FILTER_STATS_EN
    logic                runt_evt;
    logic                drop_evt;
    logic [CntWidth-1:0] pass_cnt_q, pass_cnt_d;
    logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d;
    logic                runt_q;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v,
                                                    input logic             en);
        if (en && (v != {CntWidth{1'b1}})) begin
            return v + {{(CntWidth-1){1'b0}}, 1'b1};
        end
        return v;
    endfunction

    assign runt_evt   = hdr_fire && s_axis_tlast && !last_hdr_beat;
    assign drop_evt   = runt_evt || (hdr_fire && last_hdr_beat && !accept);
    assign pass_cnt_d = sat_inc(pass_cnt_q, flush_done);
    assign drop_cnt_d = sat_inc(drop_cnt_q, drop_evt);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
            runt_q     <= 1'b0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            runt_q     <= runt_evt;
        end
    end

    assign pass_cnt_o = pass_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
    assign runt_o     = runt_q;
`else
    assign pass_cnt_o = '0;
    assign drop_cnt_o = '0;
    assign runt_o     = 1'b0;
`endif

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
`timescale 1ns/1ps
module tb_eth_rx_mac_filter;
    localparam int UW   = 2;
    localparam int CW   = 4;
    localparam int BW   = UW + 9;
    localparam int CMAX = (1 << CW) - 1;
`ifdef ETH_RX_MAC_FILTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [47:0]   mac_addr = '0;
    logic          promisc = 1'b0;
    logic          mcast_en = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_last = 1'b0;
    logic [UW-1:0] s_user = '0;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic [UW-1:0] m_user;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] drop_cnt;
    logic          runt;

    always #4 clk = ~clk;

    eth_rx_mac_filter #(.UserWidth(UW), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst), .mac_addr_i(mac_addr),
        .promisc_i(promisc), .mcast_en_i(mcast_en),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
        .s_axis_tlast(s_last), .s_axis_tuser(s_user),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .m_axis_tlast(m_last), .m_axis_tuser(m_user),
        .pass_cnt_o(pass_cnt), .drop_cnt_o(drop_cnt), .runt_o(runt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame under construction and reference model state.
    logic [7:0]    frm [128];
    logic [UW-1:0] usr [128];
    logic [BW-1:0] expq [$];
    logic [BW-1:0] got [$];
    int got_base  = 0;
    int m_pass    = 0;
    int m_drop    = 0;
    int m_runt    = 0;
    int runt_seen = 0;
    int bp_mode   = 0;

    // Output monitor: collects transferred beats, counts runt pulses and
    // checks that a stalled output beat is held stable.
    initial begin
        bit            hold_pending;
        logic [BW-1:0] held;
        hold_pending = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    chk("hold_valid", 64'(m_valid), 64'd1);
                    chk("hold_beat", 64'({m_user, m_last, m_data}), 64'(held));
                end
                if (m_valid && m_ready) got.push_back({m_user, m_last, m_data});
                if (runt) runt_seen++;
                hold_pending = m_valid && !m_ready;
                held = {m_user, m_last, m_data};
            end
        end
    end

    // Output back-pressure: mode 0 always ready, mode 1 random stall runs.
    initial begin
        int stall_left;
        stall_left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 0) begin
                m_ready = 1'b1;
            end else if (stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = 1'b1;
                if ($urandom_range(0, 9) == 0) stall_left = $urandom_range(0, 50);
            end
        end
    end

    initial begin
        #700000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic bit model_accept();
        bit uni = 1'b1;
        bit bc  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (frm[k] != mac_addr[8*k +: 8]) uni = 1'b0;
            if (frm[k] != 8'hFF) bc = 1'b0;
        end
        return promisc || uni || bc || (mcast_en && frm[0][0]);
    endfunction

    task automatic fill(input int len);
        logic [31:0] r;
        for (int i = 0; i < len; i++) begin
            r = $urandom;
            frm[i] = r[7:0];
            usr[i] = r[8 +: UW];
        end
    endtask

    task automatic set_hdr(input logic [47:0] h);
        for (int k = 0; k < 6; k++) frm[k] = h[8*k +: 8];
    endtask

    task automatic send_frame(input int len, input bit gaps, input int stop_at,
                              input int flip_at, output int stalls);
        logic [31:0] r1, r2;
        bit done;
        int t;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            if (i == stop_at) break;
            if (gaps) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            if (i == flip_at) begin
                r1 = $urandom;
                r2 = $urandom;
                mac_addr = {r1[15:0], r2};
                promisc  = r1[16];
                mcast_en = r1[17];
            end
            s_valid = 1'b1;
            s_data  = frm[i];
            s_last  = (i == len - 1);
            s_user  = usr[i];
            done = 1'b0;
            t = 0;
            while (!done) begin
                @(negedge clk);
                done = s_ready;
                if (!done) stalls++;
                tick();
                t++;
                if (!done && t > 5000) begin
                    chk("drv_timeout", 64'd0, 64'd1);
                    done = 1'b1;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_pass_cnt"}, 64'(pass_cnt), 64'(STATS ? m_pass : 0));
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(STATS ? m_drop : 0));
        chk({tag, "_runts"}, 64'(runt_seen), 64'(STATS ? m_runt : 0));
    endtask

    task automatic run_frame(input string tag, input int len, input bit gaps,
                             input int flip_at, output int stalls);
        int t;
        if (len < 6) begin
            m_runt++;
            m_drop = sat(m_drop);
        end else if (model_accept()) begin
            for (int i = 0; i < len; i++) expq.push_back({usr[i], (i == len - 1), frm[i]});
            m_pass = sat(m_pass);
        end else begin
            m_drop = sat(m_drop);
        end
        send_frame(len, gaps, -1, flip_at, stalls);
        t = 0;
        while ((got.size() - got_base) < expq.size() && t < 5000) begin
            tick();
            t++;
        end
        repeat (3) tick();
        chk({tag, "_len"}, 64'(got.size() - got_base), 64'(expq.size()));
        for (int i = 0; i < expq.size() && (got_base + i) < got.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(got[got_base + i]), 64'(expq[i]));
        got_base = got.size();
        expq.delete();
        check_stats(tag);
    endtask

    initial begin
        int st;
        logic [31:0] r;
        int len;
        int flip;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_user", 64'(m_user), 64'd0);
        chk("rst_pass_cnt", 64'(pass_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_runt", 64'(runt), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_s_ready", 64'(s_ready), 64'd1);
        tick();

        // Unicast match.
        mac_addr = 48'h2070_9800_1032;
        fill(64);
        set_hdr(48'h2070_9800_1032);
        run_frame("uni", 64, 1'b0, -1, st);

        // Mismatch: nothing out, input never stalled.
        mac_addr = 48'h2070_9800_1033;
        run_frame("mis", 64, 1'b0, -1, st);
        chk("mis_stalls", 64'(st), 64'd0);

        mac_addr = 48'h2070_9800_1032;
        fill(64);
        set_hdr(48'h2070_9800_1032);
        run_frame("uni2", 64, 1'b0, -1, st);

        // Broadcast always passes.
        fill(20);
        set_hdr(48'hFFFF_FFFF_FFFF);
        run_frame("bcast", 20, 1'b0, -1, st);

        // Multicast, disabled then enabled.
        fill(30);
        set_hdr(48'h01_00_00_5E_00_01);
        mcast_en = 1'b0;
        run_frame("mc_off", 30, 1'b0, -1, st);
        mcast_en = 1'b1;
        run_frame("mc_on", 30, 1'b0, -1, st);
        mcast_en = 1'b0;

        // Runt.
        fill(4);
        run_frame("runt", 4, 1'b0, -1, st);
        chk("runt_stalls", 64'(st), 64'd0);

        // Exactly six bytes, matching.
        fill(6);
        set_hdr(mac_addr);
        run_frame("six", 6, 1'b0, -1, st);
        chk("six_idle_ready", 64'(s_ready), 64'd1);

        // Randomized frames with back-pressure and input gaps.
        bp_mode = 1;
        for (int f = 0; f < 30; f++) begin
            r = $urandom;
            len = (r[3:0] == 4'd0) ? 6 : int'($urandom_range(1, 48));
            fill(len);
            case (r[5:4])
                2'd0: set_hdr(mac_addr);
                2'd1: set_hdr(48'hFFFF_FFFF_FFFF);
                2'd2: ;
                default: frm[0][0] = 1'b1;
            endcase
            promisc  = (r[7:6] == 2'd0);
            mcast_en = r[8];
            flip = (len > 8 && r[9]) ? 8 : -1;
            run_frame($sformatf("rnd%0d", f), len, 1'b1, flip, st);
        end
        promisc  = 1'b0;
        mcast_en = 1'b0;

        // Reset pulsed during PASS at byte 20.
        mac_addr = 48'h2070_9800_1032;
        fill(64);
        set_hdr(mac_addr);
        send_frame(64, 1'b0, 20, -1, st);
        s_valid = 1'b1;
        s_data  = frm[20];
        s_last  = 1'b0;
        s_user  = usr[20];
        rst = 1'b1;
        #1;
        chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
        chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_m_data", 64'(m_data), 64'd0);
        chk("mid_rst_m_last", 64'(m_last), 64'd0);
        s_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rel_s_ready", 64'(s_ready), 64'd1);
        m_pass = 0;
        m_drop = 0;
        expq.delete();
        got_base = got.size();
        check_stats("mid_rst");
        tick();
        fill(64);
        set_hdr(mac_addr);
        run_frame("post_rst", 64, 1'b1, -1, st);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eth_rx_mac_filter.md
# eth_rx_mac_filter

Destination-MAC filter on the 8-bit AXI-Stream receive path. It sits directly downstream of the RX framing core's `axis_rx` output and upstream of the 8→64 upsizer.
- Holds the first six bytes of each frame (the destination MAC) and compares them against the configured station address.
- Replays and forwards accepted frames unchanged.
- Silently consumes rejected and runt frames.

## Interface
Parameters:
- `UserWidth`, 1, tuser width; tuser is forwarded unchanged on every beat.
- `CntWidth`, 16, width of the saturating statistics counters.

Ports:
- `clk_i` input 1: single clock, 125 MHz system clock.
- `rst_i` input 1: asynchronous reset, active high.
- `mac_addr_i` input 48: station MAC. Byte k of the frame is compared with `mac_addr_i[8k+7:8k]`; byte 0 is the first received.
- `promisc_i` input 1: accept every frame of 6 bytes or more.
- `mcast_en_i` input 1: accept frames whose byte 0 has bit 0 set.
- `s_axis_tdata` input 8, `s_axis_tvalid` input 1, `s_axis_tready` output 1, `s_axis_tlast` input 1, `s_axis_tuser` input UserWidth: stream from the framing core.
- `m_axis_tdata` output 8, `m_axis_tvalid` output 1, `m_axis_tready` input 1, `m_axis_tlast` output 1, `m_axis_tuser` output UserWidth: stream to the upsizer.
- `pass_cnt_o` output CntWidth: count of accepted frames.
- `drop_cnt_o` output CntWidth: count of rejected frames, runts included.
- `runt_o` output 1: one-cycle pulse when a frame ends within its first 6 bytes.

## Operation
States: IDLE, HDR, FLUSH, PASS, DROP.
- Header buffer: 6×(8 + UserWidth + 1) bits, with byte index `idx` 0..5.
- **IDLE/HDR**
  - `s_axis_tready=1`; each accepted beat is written to `buf[idx]` and `idx` increments. The first beat moves IDLE→HDR.
  - tlast with `idx<5` → runt. Pulse `runt_o`, increment `drop_cnt_o`, go to IDLE.
  - On the 6th beat (`idx==5`), decide acceptance. Accept if any of:
    - `promisc_i`;
    - the 6 bytes equal `mac_addr_i`;
    - all 6 bytes are 0xFF (broadcast, always accepted);
    - `mcast_en_i` and `buf[0][0]`.
  - The decision uses the incoming 6th byte combinationally.
  - Accept → FLUSH with `idx=0`. Reject → DROP, or straight to IDLE if the 6th byte carried tlast. Every reject increments `drop_cnt_o`.
- **FLUSH**
  - `s_axis_tready=0`; `m_axis_tvalid=1`; output is `buf[idx]`; `idx` advances on `m_axis_tready`.
  - After `buf[5]` is transferred: if its tlast is set, go to IDLE, otherwise go to PASS. Either way, `pass_cnt_o` increments at this point.
- **PASS**
  - Combinational pass-through: `m_axis_* = s_axis_*`, `s_axis_tready = m_axis_tready`.
  - A transferred tlast → IDLE.
- **DROP**
  - `s_axis_tready=1`, `m_axis_tvalid=0`; beats are discarded.
  - tlast → IDLE.
- tuser (frame error) does not influence the accept decision; it is forwarded on its beat.
- Counters saturate at all-ones and never wrap.
- `mac_addr_i`, `promisc_i` and `mcast_en_i` are sampled only on the decision beat. Changing them mid-frame does not affect a frame already decided.

## Timing
- Reset values:
  - state IDLE, `idx=0`;
  - `s_axis_tready=0` while `rst_i` is high, and 1 in the first cycle after release;
  - `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`, `m_axis_tuser=0`;
  - counters 0, `runt_o=0`.
- Header latency: the first output byte is valid in the cycle after the 6th input byte is accepted.
- FLUSH with `m_axis_tready` held high: 6 cycles. During FLUSH the input is back-pressured.
- PASS adds zero latency and costs no throughput.
- DROP and HDR accept one byte per cycle.
- `m_axis_tvalid` never deasserts in FLUSH until the handshake completes, and `m_axis_tdata` is stable while `tvalid && !tready`.
- `runt_o` and counter updates are registered and visible the cycle after the terminating beat.
- Simultaneous counter increment and saturation: the counter stays at its maximum.
- `rst_i` mid-frame: the partial frame is lost and the next byte is treated as byte 0.

## Configuration
- `ETH_RX_MAC_FILTER_STATS_EN` defined: the `pass_cnt_o`/`drop_cnt_o` counter registers and `runt_o` are implemented as described.
- Not defined: no counter flops are synthesized. `pass_cnt_o`, `drop_cnt_o` and `runt_o` are tied to 0, and filtering behaviour is otherwise identical.

## Test plan
- Unicast match: `mac_addr_i=48'h2070_9800_1032`, 64-byte frame starting 32 10 00 98 70 20 → all 64 bytes out in order with tlast on byte 63; `pass_cnt_o=1`.
- Mismatch: same frame with `mac_addr_i=48'h2070_9800_1033` → no `m_axis_tvalid` at all; `s_axis_tready` stays high; `drop_cnt_o=1`. A following matching frame passes intact.
- Broadcast and multicast:
  - FF×6 frame with `promisc_i=0`, `mcast_en_i=0` → passed.
  - Frame starting 01 00 5E 00 00 01 → dropped with `mcast_en_i=0`, passed with `mcast_en_i=1`.
- Runt and boundary:
  - 4-byte frame (tlast on byte 3) → `runt_o` pulses once, `drop_cnt_o` increments, nothing output.
  - Exactly 6-byte matching frame → 6 bytes out, tlast on the 6th; FSM returns to IDLE.
- Back-pressure: random `m_axis_tready` (0–50 idle cycles) during FLUSH and PASS → byte stream and tuser are identical to the input; no beat is lost or duplicated.
- Reset mid-frame: `rst_i` pulsed during PASS at byte 20 → outputs take their reset values; the next full matching frame passes correctly; counters read 0 before that frame and 1 after it.
